subservient_multi_ram: RTL
==========================

Name: subservient_multi_ram

Overview:
- Next-generation SRAM front end for the subservient SoC.
- Shares one 1R1W SRAM macro between the serial register-file port and N Wishbone word channels (e.g. arbiter memory port plus a debug/DMA port).
- SRAM data width is parametric (8/16/32). 32-bit Wishbone words are split into SRAM-width beats, with round-robin arbitration across channels.
- Register-file traffic always has priority over Wishbone beats.

Parameters:
- depth, 512: SRAM depth in sram_dw-wide words.
- sram_dw, 8: SRAM data width. Legal values: 8, 16, 32.
- channels, 2: number of Wishbone slave channels, 1..4.
- aw, $clog2(depth): SRAM address width.

Derived values:
- beats = 32/sram_dw
- bw = $clog2(beats)
- wa = aw-bw (Wishbone word-address width)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_waddr  in  aw  RF write address
- i_wdata  in  sram_dw  RF write data
- i_wen  in  1  RF write enable
- i_raddr  in  aw  RF read address
- o_rdata  out  sram_dw  RF read data (direct from i_sram_rdata)
- i_ren  in  1  RF read enable
- i_wb_adr  in  channels*wa  word address per channel
- i_wb_dat  in  channels*32  write data per channel
- i_wb_sel  in  channels*4  byte selects per channel
- i_wb_we  in  channels  write enable per channel
- i_wb_stb  in  channels  strobe per channel
- o_wb_rdt  out  32  read data, shared bus, valid only with ack
- o_wb_ack  out  channels  one-hot ack pulse
- o_sram_waddr  out  aw  SRAM write address
- o_sram_wdata  out  sram_dw  SRAM write data
- o_sram_wmask  out  sram_dw/8  SRAM byte write mask
- o_sram_wen  out  1  SRAM write enable
- o_sram_raddr  out  aw  SRAM read address
- i_sram_rdata  in  sram_dw  SRAM read data, 1-cycle latency
- o_sram_ren  out  1  SRAM read enable
- o_stall_cnt  out  16  RF contention counter (see Optional Feature)

Behaviour:
Reset (i_rst_n low, asynchronous):
- state=IDLE, beat=0, rr pointer=0.
- o_wb_ack=0, o_wb_rdt=0.
- No SRAM strobe is issued from the Wishbone path.

SRAM port muxing (combinational):
- Write port: RF when i_wen, else the Wishbone write beat.
- Read port: RF when i_ren, else the Wishbone read beat.
- RF write and Wishbone read may proceed in the same cycle, and vice versa.

State machine: IDLE -> {WR, RD} -> ACK -> IDLE.
- IDLE:
  - If any stb is high and no ack is pending, grant the first requesting channel at or after the rr pointer.
  - Latch adr/dat/sel/we from that channel; beat=0.
  - Go to WR if we, else RD.
- WR, each cycle with i_wen=0:
  - waddr={adr,beat}, wdata=dat lane[beat], wmask=sel bits of that lane.
  - o_sram_wen=1 only if the mask is nonzero; beats with an all-zero mask are skipped with no SRAM write.
  - beat++. After beat beats-1, go to ACK.
  - i_wen=1 stalls the beat and beat holds.
- RD, each cycle with i_ren=0:
  - o_sram_ren=1, raddr={adr,beat}.
  - Data returns the next cycle and is stored into o_wb_rdt lane[beat-1]. Capture is a registered flag, independent of stalls.
  - After the last beat is issued, wait one capture cycle, then go to ACK.
  - i_ren=1 stalls the issue.
- ACK:
  - o_wb_ack[grant]=1 for exactly one cycle.
  - rr pointer = grant+1 mod channels.
  - Go to IDLE. No new grant in the ACK cycle.

Latency and ordering:
- Uncontended latency from grant: write = beats+1 cycles to ack; read = beats+2.
- A channel dropping stb mid-transaction has no effect; the transaction completes and acks.
- Byte/lane order is little-endian: beat 0 carries bits [sram_dw-1:0].
- sram_dw=32: one beat; wmask=sel.
- Wishbone address wrap: none. adr is truncated to wa bits.

Optional Feature:
Macro SUBSERVIENT_MULTI_RAM_STALL_CNT_EN.
- Defined: o_stall_cnt counts cycles in which the Wishbone path was stalled by RF priority (WR with i_wen, or RD issue with i_ren). It is 16-bit, saturating at 0xFFFF, and cleared by reset.
- Undefined: o_stall_cnt is tied to 0 and no counter logic is generated.

Test Plan:
- sram_dw=8, ch0 writes adr 3, dat 0xA1B2C3D4, sel 0xF -> SRAM writes 0xD4@12, 0xC3@13, 0xB2@14, 0xA1@15 on consecutive cycles; ack[0] at cycle 5.
- sram_dw=8, ch0 writes sel 0x4, dat 0x00EE0000 to adr 1 -> single SRAM write 0xEE@6; no other wen; ack after 5 cycles.
- sram_dw=16, ch1 reads adr 2 with SRAM preloaded 0x5678@4, 0x1234@5 -> o_wb_rdt=0x12345678 with ack[1] at cycle 4.
- ch0 and ch1 stb held high continuously, both reading -> acks alternate 0,1,0,1; no channel is granted twice in a row.
- sram_dw=8, i_ren held high for 3 cycles during a ch0 read -> read completes 3 cycles late with correct data; o_stall_cnt=3 with macro defined, 0 without.
- i_rst_n pulsed low mid-write, after beat 1 -> ack never asserts, SRAM wen drops immediately; after release, the still-asserted stb is re-granted and all 4 beats are rewritten.

Source files
------------

// File: rtl/subservient_multi_ram.sv
// Shares one 1R1W SRAM between the RF port and N round-robin Wishbone word channels.
// Optional stall counter: define SUBSERVIENT_MULTI_RAM_STALL_CNT_EN.
module subservient_multi_ram #(
    parameter int depth    = 512,
    parameter int sram_dw  = 8,
    parameter int channels = 2,
    parameter int aw       = $clog2(depth)
) (
    input  logic                                            i_clk,
    input  logic                                            i_rst_n,
    input  logic [aw-1:0]                                   i_waddr,
    input  logic [sram_dw-1:0]                              i_wdata,
    input  logic                                            i_wen,
    input  logic [aw-1:0]                                   i_raddr,
    output logic [sram_dw-1:0]                              o_rdata,
    input  logic                                            i_ren,
    input  logic [channels*(aw-$clog2(32/sram_dw))-1:0]     i_wb_adr,
    input  logic [channels*32-1:0]                          i_wb_dat,
    input  logic [channels*4-1:0]                           i_wb_sel,
    input  logic [channels-1:0]                             i_wb_we,
    input  logic [channels-1:0]                             i_wb_stb,
    output logic [31:0]                                     o_wb_rdt,
    output logic [channels-1:0]                             o_wb_ack,
    output logic [aw-1:0]                                   o_sram_waddr,
    output logic [sram_dw-1:0]                              o_sram_wdata,
    output logic [sram_dw/8-1:0]                            o_sram_wmask,
    output logic                                            o_sram_wen,
    output logic [aw-1:0]                                   o_sram_raddr,
    input  logic [sram_dw-1:0]                              i_sram_rdata,
    output logic                                            o_sram_ren,
    output logic [15:0]                                     o_stall_cnt
);
    localparam int beats = 32 / sram_dw;
    localparam int bw    = $clog2(beats);
    localparam int wa    = aw - bw;
    localparam int mw    = sram_dw / 8;
    localparam int bcw   = $clog2(beats + 1);
    localparam int cw    = (channels > 1) ? $clog2(channels) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WR   = 2'd1;
    localparam logic [1:0] RD   = 2'd2;
    localparam logic [1:0] ACK  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [bcw-1:0]     beat_q, beat_d;
    logic [cw-1:0]      rr_q, rr_d;
    logic [cw-1:0]      gnt_q, gnt_d;
    logic [wa-1:0]      adr_q, adr_d;
    logic [31:0]        dat_q, dat_d;
    logic [3:0]         sel_q, sel_d;
    logic [31:0]        rdt_q;
    logic               cap_q;
    logic [bcw-1:0]     cap_beat_q;

    logic               req_any;
    logic [cw-1:0]      req_idx;
    logic [sram_dw-1:0] lane_dat;
    logic [mw-1:0]      lane_sel;
    logic [aw-1:0]      wb_addr;
    logic               wb_wen;
    logic               wb_ren;

    // First requester at or after the round-robin pointer; the downward scan lets the nearest one win.
    always_comb begin
        int            idx;
        logic [cw-1:0] idx_c;
        req_any = 1'b0;
        req_idx = rr_q;
        idx     = 0;
        idx_c   = '0;
        for (int k = channels - 1; k >= 0; k--) begin
            idx   = (int'(rr_q) + k) % channels;
            idx_c = cw'(idx);
            if (i_wb_stb[idx_c]) begin
                req_any = 1'b1;
                req_idx = idx_c;
            end
        end
    end

    always_comb begin
        lane_dat = '0;
        lane_sel = '0;
        for (int i = 0; i < beats; i++) begin
            if (beat_q == bcw'(i)) begin
                lane_dat = dat_q[i*sram_dw +: sram_dw];
                lane_sel = sel_q[i*mw +: mw];
            end
        end
    end

    assign wb_addr = (aw'(adr_q) << bw) | aw'(beat_q);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        wb_wen  = 1'b0;
        wb_ren  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    gnt_d   = req_idx;
                    adr_d   = i_wb_adr[req_idx*wa +: wa];
                    dat_d   = i_wb_dat[req_idx*32 +: 32];
                    sel_d   = i_wb_sel[req_idx*4 +: 4];
                    beat_d  = '0;
                    state_d = i_wb_we[req_idx] ? WR : RD;
                end
            end
            WR: begin
                if (!i_wen) begin
                    wb_wen = |lane_sel;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == bcw'(beats - 1)) begin
                        state_d = ACK;
                    end
                end
            end
            RD: begin
                // beat == beats means every beat is issued and the last one is being captured now.
                if (beat_q == bcw'(beats)) begin
                    state_d = ACK;
                end else if (!i_ren) begin
                    wb_ren = 1'b1;
                    beat_d = beat_q + 1'b1;
                end
            end
            default: begin
                rr_d    = (gnt_q == cw'(channels - 1)) ? '0 : gnt_q + 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            rr_q    <= '0;
            gnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
        end
    end

    // Read data lands one cycle after issue regardless of what the RF port does meanwhile.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cap_q      <= 1'b0;
            cap_beat_q <= '0;
            rdt_q      <= '0;
        end else begin
            cap_q      <= wb_ren;
            cap_beat_q <= beat_q;
            for (int i = 0; i < beats; i++) begin
                if (cap_q && cap_beat_q == bcw'(i)) begin
                    rdt_q[i*sram_dw +: sram_dw] <= i_sram_rdata;
                end
            end
        end
    end

    always_comb begin
        o_wb_ack = '0;
        if (state_q == ACK) begin
            o_wb_ack[gnt_q] = 1'b1;
        end
    end

    assign o_wb_rdt     = rdt_q;
    assign o_rdata      = i_sram_rdata;
    assign o_sram_waddr = i_wen ? i_waddr : wb_addr;
    assign o_sram_wdata = i_wen ? i_wdata : lane_dat;
    assign o_sram_wmask = i_wen ? {mw{1'b1}} : lane_sel;
    assign o_sram_wen   = i_wen | wb_wen;
    assign o_sram_raddr = i_ren ? i_raddr : wb_addr;
    assign o_sram_ren   = i_ren | wb_ren;

`ifdef SUBSERVIENT_MULTI_RAM_STALL_CNT_EN
    logic        stall;
    logic [15:0] stall_cnt_q;

    assign stall = ((state_q == WR) && i_wen) ||
                   ((state_q == RD) && (beat_q != bcw'(beats)) && i_ren);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`else
    assign o_stall_cnt = 16'd0;
`endif

endmodule
